// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator
// Description : Pixel-clock divider plus column/row raster counters with
//               zero-skew sync, blanking, frame-start and colour gating.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] iRGB,
    output logic [9:0] oColumnCount,
    output logic [9:0] oRowCount,
    output logic       oHSync,
    output logic       oVSync,
    output logic       oVideoOn,
    output logic       oPixelTick,
    output logic       oFrameStart,
    output logic [2:0] oRGB
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    // 11-bit limits so a sync window ending exactly at 1024 cannot alias to 0
    localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] c_HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] c_VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [c_DIV_W-1:0] r_div;
    logic               r_run;
    logic [9:0]         r_col;
    logic [9:0]         r_row;
    logic               r_frame_start;

    logic [10:0] w_col_ext;
    logic [10:0] w_row_ext;
    logic        w_div_last;
    logic        w_tick;
    logic        w_col_last;
    logic        w_row_last;
    logic        w_video_on;

    assign w_col_ext  = {1'b0, r_col};
    assign w_row_ext  = {1'b0, r_row};
    assign w_div_last = (r_div == c_DIV_LAST);
    // r_run masks the tick in the cycle right after reset, which matters when CLK_DIV is 1
    assign w_tick     = r_run & w_div_last;
    assign w_col_last = (w_col_ext == c_H_LAST);
    assign w_row_last = (w_row_ext == c_V_LAST);
    assign w_video_on = r_run & (w_col_ext < c_H_VIS) & (w_row_ext < c_V_VIS);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_run         <= 1'b0;
            r_div         <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_frame_start <= w_tick & w_col_last & w_row_last;
            if (r_run) begin
                r_div <= w_div_last ? '0 : r_div + c_DIV_W'(1);
            end
            if (w_tick) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    // Sync and blanking decode straight from the live counts, so there is no skew
    assign oColumnCount = r_col;
    assign oRowCount    = r_row;
    assign oHSync       = !((w_col_ext >= c_HS_START) && (w_col_ext < c_HS_END));
    assign oVSync       = !((w_row_ext >= c_VS_START) && (w_row_ext < c_VS_END));
    assign oVideoOn     = w_video_on;
    assign oPixelTick   = w_tick;
    assign oFrameStart  = r_frame_start;
    assign oRGB         = w_video_on ? iRGB : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_generator
// Description : Scoreboard bench: a default 640x480 instance and a small
//               32x15 raster with CLK_DIV=1, checked tick by tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;

    typedef logic [25:0] rec_t;   // {col, row, hsync, vsync, video_on, rgb}

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [2:0] rgb_in_a, rgb_in_b;
    logic [9:0] col_a, row_a, col_b, row_b;
    logic       hs_a, vs_a, von_a, tick_a, fs_a;
    logic       hs_b, vs_b, von_b, tick_b, fs_b;
    logic [2:0] rgb_a, rgb_b;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   rel_a = 0, rel_b = 0, last_line_a = -1, last_fs_b = -1;
    int   fs_a_cnt = 0, fs_b_cnt = 0;
    bit   first_a = 1'b0, first_b = 1'b0;
    rec_t q_a[$], q_b[$];
    logic [19:0] prev_a = '0, prev_b = '0;

    vga_timing_generator dut_a (
        .Clock(clk), .Reset(rst_a), .iRGB(rgb_in_a),
        .oColumnCount(col_a), .oRowCount(row_a), .oHSync(hs_a), .oVSync(vs_a),
        .oVideoOn(von_a), .oPixelTick(tick_a), .oFrameStart(fs_a), .oRGB(rgb_a)
    );

    vga_timing_generator #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(1)
    ) dut_b (
        .Clock(clk), .Reset(rst_b), .iRGB(rgb_in_b),
        .oColumnCount(col_b), .oRowCount(row_b), .oHSync(hs_b), .oVSync(vs_b),
        .oVideoOn(von_b), .oPixelTick(tick_b), .oFrameStart(fs_b), .oRGB(rgb_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hand-derived windows for 640x480: hsync low 656..751, vsync low 490..491
    function automatic rec_t exp_a(input int t, input logic [2:0] rgb);
        int c, r;
        logic hs, vs, von;
        c   = t % 800;
        r   = (t / 800) % 525;
        hs  = !(c >= 656 && c < 752);
        vs  = !(r >= 490 && r < 492);
        von = (c < 640) && (r < 480);
        return {10'(c), 10'(r), hs, vs, von, von ? rgb : 3'b000};
    endfunction

    // Small raster: 32 columns (hsync low 20..25), 15 rows (vsync low 10..11)
    function automatic rec_t exp_b(input int t, input logic [2:0] rgb);
        int c, r;
        logic hs, vs, von;
        c   = t % 32;
        r   = (t / 32) % 15;
        hs  = !(c >= 20 && c < 26);
        vs  = !(r >= 10 && r < 12);
        von = (c < 16) && (r < 8);
        return {10'(c), 10'(r), hs, vs, von, von ? rgb : 3'b000};
    endfunction

    // Monitors: pop one expectation per pixel tick
    always @(negedge clk) begin
        if (tick_a) begin
            if (q_a.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_extra_tick: actual tick at col %0d row %0d, required no tick", col_a, row_a);
            end else begin
                check("a_tick", 40'({col_a, row_a, hs_a, vs_a, von_a, rgb_a}), 40'(q_a.pop_front()));
            end
            if (first_a) begin
                first_a = 1'b0;
                check("a_first_tick_latency", 40'(cyc - rel_a), 40'(2));
            end
            check("a_hold_between_ticks", 40'({col_a, row_a}), 40'(prev_a));
            if (col_a == 10'd0) begin
                if (last_line_a >= 0) check("a_line_period", 40'(cyc - last_line_a), 40'(1600));
                last_line_a = cyc;
            end
        end
        if (fs_a) fs_a_cnt++;
        prev_a = {col_a, row_a};
    end

    always @(negedge clk) begin
        if (tick_b) begin
            if (q_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_extra_tick: actual tick at col %0d row %0d, required no tick", col_b, row_b);
            end else begin
                check("b_tick", 40'({col_b, row_b, hs_b, vs_b, von_b, rgb_b}), 40'(q_b.pop_front()));
            end
            if (first_b) begin
                first_b = 1'b0;
                check("b_first_tick_latency", 40'(cyc - rel_b), 40'(1));
            end
        end
        if (fs_b) begin
            fs_b_cnt++;
            check("b_frame_start_wrap", {prev_b, col_b, row_b}, {10'd31, 10'd14, 10'd0, 10'd0});
            if (last_fs_b >= 0) check("b_frame_period", 40'(cyc - last_fs_b), 40'(480));
            last_fs_b = cyc;
        end
        prev_b = {col_b, row_b};
    end

    // {col,row,hs,vs,von,tick,fs,rgb} while held in reset
    localparam logic [39:0] RST_VEC = 40'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000});

    initial begin
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        rgb_in_a = 3'b101;
        rgb_in_b = 3'b011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_reset_state", 40'({col_a, row_a, hs_a, vs_a, von_a, tick_a, fs_a, rgb_a}), RST_VEC);
        check("b_reset_state", 40'({col_b, row_b, hs_b, vs_b, von_b, tick_b, fs_b, rgb_b}), RST_VEC);

        // Default raster: two full lines plus part of a third
        for (int t = 0; t < 1700; t++) q_a.push_back(exp_a(t, rgb_in_a));
        rst_a   = 1'b1;
        rel_a   = cyc;
        first_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("a_video_on_after_release", 40'({col_a, row_a, von_a, rgb_a}), 40'({10'd0, 10'd0, 1'b1, 3'b101}));
        repeat (3400) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("a_reset_after_run", 40'({col_a, row_a, hs_a, vs_a, von_a, tick_a, fs_a, rgb_a}), RST_VEC);
        check("a_queue_drained", 40'(q_a.size()), 40'(0));

        // Small raster: two frames then reset at col 23 row 11 (both syncs low)
        for (int t = 0; t <= 1335; t++) q_b.push_back(exp_b(t, rgb_in_b));
        rst_b   = 1'b1;
        rel_b   = cyc;
        first_b = 1'b1;
        repeat (1336) @(posedge clk);
        @(negedge clk);
        check("b_pos_before_reset", 40'({col_b, row_b, hs_b, vs_b}), 40'({10'd23, 10'd11, 1'b0, 1'b0}));
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_mid_frame_reset", 40'({col_b, row_b, hs_b, vs_b, von_b, tick_b, fs_b, rgb_b}), RST_VEC);
        check("b_queue_drained_1", 40'(q_b.size()), 40'(0));
        last_fs_b = -1;

        // Restart with a different colour; run past one line wrap
        rgb_in_b = 3'b110;
        @(negedge clk);
        for (int t = 0; t < 40; t++) q_b.push_back(exp_b(t, rgb_in_b));
        rst_b   = 1'b1;
        rel_b   = cyc;
        first_b = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_queue_drained_2", 40'(q_b.size()), 40'(0));
        check("a_frame_start_count", 40'(fs_a_cnt), 40'(0));
        check("b_frame_start_count", 40'(fs_b_cnt), 40'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
